// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared widths and entry layout for the fetch queue
package fetch_queue_pkg;

  localparam int ADDR_LEN     = 32;
  localparam int INSN_LEN     = 32;
  localparam int BHR_LEN      = 10;
  localparam int FQ_ENTRY_LEN = INSN_LEN + 2*ADDR_LEN + 1 + BHR_LEN;

  typedef struct packed {
    logic [INSN_LEN-1:0] inst;
    logic [ADDR_LEN-1:0] pc;
    logic [ADDR_LEN-1:0] npc;
    logic                pred;
    logic [BHR_LEN-1:0]  bhr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-side bundle input and decode-side two-slot output
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int A_LEN = ADDR_LEN,
  parameter int I_LEN = INSN_LEN,
  parameter int B_LEN = BHR_LEN
) ();

  logic             in_valid;
  logic [A_LEN-1:0] in_pc;
  logic [I_LEN-1:0] in_inst1;
  logic [I_LEN-1:0] in_inst2;
  logic             in_invalid2;
  logic [A_LEN-1:0] in_npc;
  logic             in_predict_cond;
  logic [B_LEN-1:0] in_bhr;
  logic             in_ready;

  logic             out_ready;
  logic             out_valid1, out_valid2;
  logic [I_LEN-1:0] out_inst1, out_inst2;
  logic [A_LEN-1:0] out_pc1, out_pc2;
  logic [A_LEN-1:0] out_npc1, out_npc2;
  logic             out_pred1, out_pred2;
  logic [B_LEN-1:0] out_bhr1, out_bhr2;

  modport slave (
    input  in_valid, in_pc, in_inst1, in_inst2, in_invalid2, in_npc, in_predict_cond, in_bhr,
    output in_ready,
    input  out_ready,
    output out_valid1, out_valid2, out_inst1, out_inst2, out_pc1, out_pc2,
    output out_npc1, out_npc2, out_pred1, out_pred2, out_bhr1, out_bhr2
  );

  modport master (
    output in_valid, in_pc, in_inst1, in_inst2, in_invalid2, in_npc, in_predict_cond, in_bhr,
    input  in_ready,
    output out_ready,
    input  out_valid1, out_valid2, out_inst1, out_inst2, out_pc1, out_pc2,
    input  out_npc1, out_npc2, out_pred1, out_pred2, out_bhr1, out_bhr2
  );

endinterface

// File: rtl/fetch_queue_ram.sv
// rtl/fetch_queue_ram.sv - entry array with writes at idx/idx+1 and async reads at idx/idx+1
module fq_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = FQ_ENTRY_LEN,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we0,
  input  logic             we1,
  input  logic [AW-1:0]    widx,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic [AW-1:0]    ridx,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               widx1, ridx1;

  always_comb begin
    widx1 = widx + AW'(1);
    ridx1 = ridx + AW'(1);
    mem_d = mem_q;
    if (we0) mem_d[widx]  = wdata0;
    if (we1) mem_d[widx1] = wdata1;
    rdata0 = mem_q[ridx];
    rdata1 = mem_q[ridx1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mem_q <= '0;
    else        mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-wide fetch-to-decode FIFO with bundle split and mispredict flush
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int A_LEN    = ADDR_LEN,
  parameter int I_LEN    = INSN_LEN,
  parameter int B_LEN    = BHR_LEN,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  fetch_queue_if.slave  fq,
  output logic [CW-1:0] count
);

  localparam int EW = I_LEN + 2*A_LEN + 1 + B_LEN;

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready, push, valid1, valid2, we0, we1;
  logic [1:0]    push_n, pop_n;
  logic [EW-1:0] wdata0, wdata1, rdata0, rdata1;
  logic [A_LEN-1:0] pc_plus4;

  always_comb begin
    valid1   = count_q != '0;
    valid2   = count_q >= CW'(2);
    // Depends on registered count only, so no in->out combinational path.
    in_ready = count_q <= CW'(DEPTH - 2);
    push     = fq.in_valid && in_ready;
    push_n   = !push ? 2'd0 : (fq.in_invalid2 ? 2'd1 : 2'd2);
    pop_n    = !fq.out_ready ? 2'd0 : (valid2 ? 2'd2 : (valid1 ? 2'd1 : 2'd0));
    we0      = push && !flush;
    we1      = push && !flush && !fq.in_invalid2;

    pc_plus4 = fq.in_pc + A_LEN'(4);
    wdata0   = fq.in_invalid2
             ? {fq.in_inst1, fq.in_pc, fq.in_npc, fq.in_predict_cond, fq.in_bhr}
             : {fq.in_inst1, fq.in_pc, pc_plus4, 1'b0, fq.in_bhr};
    wdata1   = {fq.in_inst2, pc_plus4, fq.in_npc, fq.in_predict_cond, fq.in_bhr};

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(pop_n);
      tail_d  = tail_q + AW'(push_n);
      count_d = count_q + CW'(push_n) - CW'(pop_n);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  fq_ram #(.DEPTH(DEPTH), .WIDTH(EW)) u_ram (
    .clk    (clk),
    .reset  (reset),
    .we0    (we0),
    .we1    (we1),
    .widx   (tail_q),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .ridx   (head_q),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  // Entry layout, MSB first: inst | pc | npc | pred | bhr.
  always_comb begin
    fq.in_ready   = in_ready;
    fq.out_valid1 = valid1;
    fq.out_valid2 = valid2;
    fq.out_inst1  = valid1 ? rdata0[EW-1 -: I_LEN]           : '0;
    fq.out_pc1    = valid1 ? rdata0[EW-I_LEN-1 -: A_LEN]     : '0;
    fq.out_npc1   = valid1 ? rdata0[B_LEN+1 +: A_LEN]        : '0;
    fq.out_pred1  = valid1 ? rdata0[B_LEN]                   : 1'b0;
    fq.out_bhr1   = valid1 ? rdata0[B_LEN-1:0]               : '0;
    fq.out_inst2  = valid2 ? rdata1[EW-1 -: I_LEN]           : '0;
    fq.out_pc2    = valid2 ? rdata1[EW-I_LEN-1 -: A_LEN]     : '0;
    fq.out_npc2   = valid2 ? rdata1[B_LEN+1 +: A_LEN]        : '0;
    fq.out_pred2  = valid2 ? rdata1[B_LEN]                   : 1'b0;
    fq.out_bhr2   = valid2 ? rdata1[B_LEN-1:0]               : '0;
  end

  assign count = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    ({1'b0, count_q} + (CW+1)'(push_n)) <= (CW+1)'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    CW'(pop_n) <= count_q);
  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard testbench for fetch_queue
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] count;

  fetch_queue_if fq ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .fq    (fq.slave),
    .count (count)
  );

  always #5 clk = ~clk;

  fq_entry_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares presented slots against the scoreboard and retires consumed entries.
  always @(negedge clk) begin
    int sz;
    fq_entry_t s1, s2;
    if (reset) begin
      sz = sb.size();
      chk("mon_count", 128'(count), 128'(sz));
      chk("mon_in_ready", 128'(fq.in_ready), 128'(DEPTH - sz >= 2));
      chk("mon_valid1", 128'(fq.out_valid1), 128'(sz >= 1));
      chk("mon_valid2", 128'(fq.out_valid2), 128'(sz >= 2));
      s1 = '{inst: fq.out_inst1, pc: fq.out_pc1, npc: fq.out_npc1, pred: fq.out_pred1, bhr: fq.out_bhr1};
      s2 = '{inst: fq.out_inst2, pc: fq.out_pc2, npc: fq.out_npc2, pred: fq.out_pred2, bhr: fq.out_bhr2};
      if (fq.out_valid1 && sz >= 1) chk("mon_slot1", 128'(s1), 128'(sb[0]));
      if (fq.out_valid2 && sz >= 2) chk("mon_slot2", 128'(s2), 128'(sb[1]));
      if (!fq.out_valid2) chk("mon_slot2_zero", 128'(s2), 128'(0));
      if (fq.out_ready) begin
        if (sz >= 1) void'(sb.pop_front());
        if (sz >= 2) void'(sb.pop_front());
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] i1,
                      input logic [31:0] i2, input logic inv2, input logic [31:0] npc,
                      input logic pred, input logic [9:0] bhr, input logic ordy,
                      input logic fl);
    int sz;
    fq.in_valid        = v;
    fq.in_pc           = pc;
    fq.in_inst1        = i1;
    fq.in_inst2        = i2;
    fq.in_invalid2     = inv2;
    fq.in_npc          = npc;
    fq.in_predict_cond = pred;
    fq.in_bhr          = bhr;
    fq.out_ready       = ordy;
    flush              = fl;
    sz = sb.size();
    @(posedge clk);
    if (fl) sb.delete();
    else if (v && (DEPTH - sz >= 2)) begin
      if (inv2) sb.push_back('{inst: i1, pc: pc, npc: npc, pred: pred, bhr: bhr});
      else begin
        sb.push_back('{inst: i1, pc: pc, npc: pc + 32'd4, pred: 1'b0, bhr: bhr});
        sb.push_back('{inst: i2, pc: pc + 32'd4, npc: npc, pred: pred, bhr: bhr});
      end
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 10'h0, ordy, 1'b0);
  endtask

  task automatic bundle2(input logic [31:0] pc, input logic ordy);
    step(1'b1, pc, {16'hA000, pc[15:0]}, {16'hB000, pc[15:0]}, 1'b0, pc + 32'h40,
         pc[3], pc[9:0] ^ 10'h2AA, ordy, 1'b0);
  endtask

  initial begin
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 10'h0, 1'b0, 1'b0);
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_in_ready", 128'(fq.in_ready), 128'(1));
    chk("rst_valid1", 128'(fq.out_valid1), 128'(0));
    chk("rst_valid2", 128'(fq.out_valid2), 128'(0));
    reset = 1'b1;
    idle(1'b0);

    // Two-wide split
    step(1'b1, 32'h100, 32'hAAAA0013, 32'hBBBB0013, 1'b0, 32'h200, 1'b1, 10'h155, 1'b0, 1'b0);
    chk("split_pc1", 128'(fq.out_pc1), 128'h100);
    chk("split_npc1", 128'(fq.out_npc1), 128'h104);
    chk("split_pred1", 128'(fq.out_pred1), 128'h0);
    chk("split_inst1", 128'(fq.out_inst1), 128'hAAAA0013);
    chk("split_pc2", 128'(fq.out_pc2), 128'h104);
    chk("split_npc2", 128'(fq.out_npc2), 128'h200);
    chk("split_pred2", 128'(fq.out_pred2), 128'h1);
    chk("split_inst2", 128'(fq.out_inst2), 128'hBBBB0013);
    chk("split_bhr1", 128'(fq.out_bhr1), 128'h155);
    chk("split_bhr2", 128'(fq.out_bhr2), 128'h155);
    idle(1'b1);
    chk("split_drained", 128'(count), 128'(0));

    // Single-instruction bundle
    step(1'b1, 32'h10C, 32'h11110013, 32'hDEAD0013, 1'b1, 32'h110, 1'b0, 10'h0AA, 1'b0, 1'b0);
    chk("single_count", 128'(count), 128'(1));
    chk("single_valid1", 128'(fq.out_valid1), 128'(1));
    chk("single_valid2", 128'(fq.out_valid2), 128'(0));
    chk("single_npc1", 128'(fq.out_npc1), 128'h110);
    chk("single_inst2", 128'(fq.out_inst2), 128'h0);
    idle(1'b1);

    // Fill and back-pressure
    for (int k = 0; k < 4; k++) bundle2(32'h200 + 32'(8*k), 1'b0);
    chk("fill_count", 128'(count), 128'(8));
    chk("fill_in_ready", 128'(fq.in_ready), 128'(0));
    bundle2(32'h300, 1'b0);
    chk("drop_count", 128'(count), 128'(8));
    chk("drop_head_pc", 128'(fq.out_pc1), 128'h200);
    idle(1'b1);
    chk("bp_count", 128'(count), 128'(6));
    chk("bp_in_ready", 128'(fq.in_ready), 128'(1));

    // Flush beats same-cycle enqueue and dequeue
    step(1'b1, 32'h500, 32'h55550013, 32'h66660013, 1'b0, 32'h600, 1'b1, 10'h3FF, 1'b1, 1'b1);
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_valid1", 128'(fq.out_valid1), 128'(0));
    step(1'b1, 32'h400, 32'h44440013, 32'h0, 1'b1, 32'h800, 1'b1, 10'h001, 1'b0, 1'b0);
    chk("post_flush_pc1", 128'(fq.out_pc1), 128'h400);
    chk("post_flush_npc1", 128'(fq.out_npc1), 128'h800);
    idle(1'b1);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 10'h0, 1'b0, 1'b1);
    chk("flush_empty", 128'(count), 128'(0));

    // Streaming across pointer wrap
    for (int k = 0; k < 20; k++) begin
      bundle2(32'h1000 + 32'(8*k), 1'b1);
      chk("stream_count", 128'(count), 128'(2));
      chk("stream_pc1", 128'(fq.out_pc1), 128'(32'h1000 + 32'(8*k)));
    end
    idle(1'b1);
    chk("stream_drained", 128'(count), 128'(0));

    // Asynchronous reset with entries held
    bundle2(32'h2000, 1'b0);
    bundle2(32'h2008, 1'b0);
    step(1'b1, 32'h2010, 32'h77770013, 32'h0, 1'b1, 32'h2014, 1'b0, 10'h011, 1'b0, 1'b0);
    chk("pre_reset_count", 128'(count), 128'(5));
    #2 reset = 1'b0;
    #1;
    chk("async_count", 128'(count), 128'(0));
    chk("async_valid1", 128'(fq.out_valid1), 128'(0));
    chk("async_valid2", 128'(fq.out_valid2), 128'(0));
    chk("async_in_ready", 128'(fq.in_ready), 128'(1));
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    idle(1'b1);
    idle(1'b1);
    chk("empty_pop_count", 128'(count), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- 2-wide decoupling FIFO between the fetch stage and decode.
- Captures each fetched bundle (1 or 2 instructions, PC, predicted next PC, predict flag, BHR snapshot) and presents up to two oldest instructions per cycle to decode.
- Back-pressures the PC stage when fewer than 2 entries are free.
- Flushes completely on branch mispredict.

Parameters:
- DEPTH, 8, number of single-instruction entries; power of 2, at least 4.
- ADDR_LEN, 32, PC width.
- INSN_LEN, 32, instruction width.
- BHR_LEN, 10, global history width (matches GSH_BHR_LEN).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch bundle present this cycle.
- in_pc  in  ADDR_LEN  PC of inst1.
- in_inst1  in  INSN_LEN  first instruction.
- in_inst2  in  INSN_LEN  second instruction.
- in_invalid2  in  1  inst2 not part of the bundle.
- in_npc  in  ADDR_LEN  predicted next-fetch PC of the bundle.
- in_predict_cond  in  1  predictor taken flag for the bundle.
- in_bhr  in  BHR_LEN  BHR snapshot at fetch.
- in_ready  out  1  queue can accept a full bundle; PC stage stalls when 0.
- flush  in  1  mispredict kill (prmiss).
- out_ready  in  1  decode consumes all valid output slots this cycle.
- out_valid1  out  1  head slot valid.
- out_valid2  out  1  head+1 slot valid.
- out_inst1, out_inst2  out  INSN_LEN  instructions.
- out_pc1, out_pc2  out  ADDR_LEN  instruction PCs.
- out_npc1, out_npc2  out  ADDR_LEN  predicted successor PC per instruction.
- out_pred1, out_pred2  out  1  predicted-taken per instruction.
- out_bhr1, out_bhr2  out  BHR_LEN  BHR snapshot per instruction.
- count  out  clog2(DEPTH)+1  occupied entries.

Behaviour:
- Entry fields: inst, pc, npc, pred, bhr.
- Reset (reset=0, asynchronous):
  - head/tail pointers and count = 0.
  - out_valid1/2 = 0; in_ready = 1.
  - All entry fields clear to 0.
- Bundle split on enqueue (when in_valid && in_ready):
  - Two-instruction bundle (in_invalid2=0):
    - entry A = {in_inst1, in_pc, in_pc+4, 0, in_bhr}.
    - entry B = {in_inst2, in_pc+4, in_npc, in_predict_cond, in_bhr}.
    - tail += 2.
  - One-instruction bundle (in_invalid2=1):
    - entry A = {in_inst1, in_pc, in_npc, in_predict_cond, in_bhr}.
    - tail += 1.
  - PC adds are ADDR_LEN-bit modulo.
- in_ready = (DEPTH - count) >= 2, combinational from registered count only. It does not depend on same-cycle dequeue, so there is no in/out combinational path.
- in_valid while in_ready=0: bundle ignored; fetch holds PC.
- Dequeue:
  - out_valid1 = count >= 1; out_valid2 = count >= 2.
  - Output data read combinationally from entries head and head+1 (mod DEPTH).
  - Data outputs are forced to 0 when the corresponding valid is 0.
  - out_ready=1 pops (out_valid1 + out_valid2) entries; out_ready with count=0 has no effect.
- Simultaneous enqueue and dequeue: count_next = count + pushed - popped. Pointers wrap mod DEPTH with no bubble.
- Flush has top priority:
  - count, head and tail go to 0 at the next edge.
  - Same-cycle enqueue and dequeue are discarded.
  - Outputs are invalid the cycle after.
  - Flush while empty is a no-op.
- Latency: an instruction enqueued at edge N is visible on out_* in cycle N+1 if it is at the head.
- Throughput: sustains 2 insn/cycle when in and out both stream.
- Invariant: count <= DEPTH always. Overflow and underflow are unreachable; assertions required.

Decomposition:
- Shared package: ADDR_LEN, INSN_LEN, BHR_LEN defaults (existing constants header); packed entry width constant FQ_ENTRY_LEN = INSN_LEN + 2*ADDR_LEN + 1 + BHR_LEN.
- One sub-module: fq_ram, a DEPTH x FQ_ENTRY_LEN register array.
  - 2 write ports: idx, idx+1.
  - 2 asynchronous read ports.
  - Async active-low clear.
- Pointer/count/flush control stays in fetch_queue.

Test Plan:
- Reset and empty read: reset low mid-run with count=5 → count=0, out_valid1/2=0, in_ready=1 immediately (async). With out_ready=1 and no input → count stays 0.
- Two-wide split: in_pc=0x100, inst1=0xAAAA0013, inst2=0xBBBB0013, in_invalid2=0, in_npc=0x200, pred=1, bhr=0x155 → next cycle out_pc1=0x100, out_npc1=0x104, out_pred1=0; out_pc2=0x104, out_npc2=0x200, out_pred2=1; both bhr=0x155.
- Single bundle: in_pc=0x10C, in_invalid2=1, in_npc=0x110, pred=0 → count=1, out_valid1=1, out_valid2=0, out_npc1=0x110, out_inst2=0.
- Fill/back-pressure: out_ready=0, 4 two-wide bundles with DEPTH=8 → count=8, in_ready=0. A fifth bundle is dropped. One out_ready pulse → count=6, in_ready=1.
- Wrap and concurrent push/pop: stream 20 two-wide bundles with out_ready=1 → count stays 2 each steady cycle. PCs emerge in order across pointer wrap; no gaps or duplicates.
- Flush priority: count=6, flush=1 with in_valid=1 and out_ready=1 in the same cycle → count=0 next cycle, nothing from that cycle enqueued. The following bundle at in_pc=0x400 appears as out_pc1=0x400.
